mem_req_arbiter: RTL and testbench
==================================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameter OUTSTANDING_DEPTH, default 4 (power of two, 2..8), is the max accepted-but-unanswered downstream transactions.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 inst_req  input  1  instruction-side read request.
REQ-005 inst_addr  input  32  instruction fetch physical address.
REQ-006 inst_addr_ok  output  1  instruction request accepted this cycle.
REQ-007 inst_data_ok  output  1  instruction read data valid this cycle.
REQ-008 inst_rdata  output  32  instruction read data.
REQ-009 data_req  input  1  data-side request.
REQ-010 data_wr  input  1  1 = store, 0 = load.
REQ-011 data_size  input  3  access size (0 = byte, 1 = half, 2 = word).
REQ-012 data_addr  input  32  data physical address.
REQ-013 data_wstrb  input  4  store byte strobes.
REQ-014 data_wdata  input  32  store data.
REQ-015 data_addr_ok  output  1  data request accepted this cycle.
REQ-016 data_data_ok  output  1  load data valid / store acknowledged.
REQ-017 data_rdata  output  32  load data.
REQ-018 mem_req, mem_wr (1), mem_size (3), mem_addr (32), mem_wstrb (4), mem_wdata (32)  output  shared downstream request bus.
REQ-019 mem_addr_ok, mem_data_ok (1), mem_rdata (32)  input  downstream handshake and read data; responses return in request order.

Function
REQ-020 Handshake: a transfer is accepted in a cycle where mem_req & mem_addr_ok; exactly the granted requester's addr_ok equals mem_addr_ok in that cycle, the other's is 0.
REQ-021 Grant FSM states IDLE, HOLD_I, HOLD_D; in IDLE grant is computed combinationally, data beating inst when both request (fixed priority, see REQ-031).
REQ-022 IDLE -> HOLD_x when a grant is issued but mem_addr_ok is 0; HOLD_x keeps the grant (mem_* bus stable) regardless of the other requester until accepted, then -> IDLE; if the held requester drops req, mem_req = 0 and -> IDLE.
REQ-023 Instruction grant drives mem_wr = 0, mem_size = 2, mem_wstrb = 0, mem_wdata = 0; data grant passes data_* through unchanged.
REQ-024 Each accepted transfer pushes its owner bit (0 inst, 1 data) into an OUTSTANDING_DEPTH-entry owner FIFO; each mem_data_ok pops the head.
REQ-025 mem_data_ok routes to inst_data_ok or data_data_ok per popped owner, same cycle (zero latency); mem_rdata is driven on both rdata ports.
REQ-026 Count width clog2(DEPTH+1); push and pop in the same cycle leave count unchanged; pointers wrap modulo DEPTH.
REQ-027 Full (count == DEPTH): mem_req = 0 and both addr_ok = 0, even if mem_data_ok pops that cycle; FSM state is held.
REQ-028 mem_data_ok while empty is ignored: no data_ok, count stays 0.

Reset
REQ-029 On reset: FSM IDLE, count 0, pointers 0, last-winner = inst; all outputs 0 in the reset cycle, and 0 afterwards while no requests or responses arrive.
REQ-030 Reset mid-operation discards all outstanding owners; later stray mem_data_ok is handled per REQ-028.

Configuration
REQ-031 Macro ARB_ROUND_ROBIN_EN: when defined, IDLE ties go to the requester not granted last (last-winner updates on each accept); when undefined, data always wins ties and last-winner is not implemented.

Verification
REQ-032 inst_req and data_req both 1 from reset, mem_addr_ok = 1 -> first accept is data; without macro data wins every tie; with macro grants alternate D,I,D,I.
REQ-033 Data store to 0x1FC0_0010 with mem_addr_ok = 0 for 3 cycles while inst_req rises -> mem_addr/mem_wdata stable 4 cycles, grant stays data, data_addr_ok only in cycle 4.
REQ-034 Four accepts (I,D,I,D), no data_ok -> 5th request blocked with mem_req = 0; then mem_data_ok pulses -> inst, data, inst, data data_ok in order with matching rdata.
REQ-035 At count = 3, accept and mem_data_ok in the same cycle -> count stays 3; at count = 4 with mem_data_ok -> no accept that cycle, count 3 next cycle.
REQ-036 Two outstanding, reset asserted one cycle, then mem_data_ok pulses -> no data_ok asserted, count 0.
REQ-037 mem_data_ok with empty FIFO after reset -> both data_ok remain 0.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Two-requester (instruction/data) arbiter onto one in-order memory request bus.
// Optional build macro ARB_ROUND_ROBIN_EN: ties alternate instead of data always winning.
//
// state  | meaning
// IDLE   | no grant pending; grant decided combinationally each cycle
// HOLD_I | instruction grant waiting for mem_addr_ok, bus held stable
// HOLD_D | data grant waiting for mem_addr_ok, bus held stable
module mem_req_arbiter #(
  parameter int OUTSTANDING_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [2:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam int PW = $clog2(OUTSTANDING_DEPTH);
  localparam int CW = $clog2(OUTSTANDING_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                count_q;
  logic [PW-1:0]                wr_ptr_q, rd_ptr_q;
  logic [OUTSTANDING_DEPTH-1:0] owner_q;
  logic                         full, gnt_i, gnt_d, accept, pop, head_owner, data_wins;

  assign full       = (count_q == CW'(OUTSTANDING_DEPTH));
  assign head_owner = owner_q[rd_ptr_q];
  assign accept     = !reset && (gnt_i || gnt_d) && mem_addr_ok;
  assign pop        = !reset && mem_data_ok && (count_q != '0);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_data_q;

  always_ff @(posedge clk) begin
    if (reset)
      last_data_q <= 1'b0;
    else if (accept)
      last_data_q <= gnt_d;
  end

  assign data_wins = !last_data_q;
`else
  assign data_wins = 1'b1;
`endif

  // A full owner FIFO freezes the grant logic entirely, including any hold.
  always_comb begin
    state_d = state_q;
    gnt_i   = 1'b0;
    gnt_d   = 1'b0;
    if (!full) begin
      case (state_q)
        IDLE: begin
          if (data_req && (!inst_req || data_wins))
            gnt_d = 1'b1;
          else if (inst_req)
            gnt_i = 1'b1;
          if (gnt_d && !mem_addr_ok)
            state_d = HOLD_D;
          else if (gnt_i && !mem_addr_ok)
            state_d = HOLD_I;
        end
        HOLD_I: begin
          gnt_i   = inst_req;
          state_d = (inst_req && !mem_addr_ok) ? HOLD_I : IDLE;
        end
        HOLD_D: begin
          gnt_d   = data_req;
          state_d = (data_req && !mem_addr_ok) ? HOLD_D : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = 3'd0;
    mem_addr     = 32'd0;
    mem_wstrb    = 4'd0;
    mem_wdata    = 32'd0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    inst_rdata   = 32'd0;
    data_rdata   = 32'd0;
    if (!reset) begin
      mem_req = gnt_i || gnt_d;
      if (gnt_d) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_addr  = data_addr;
        mem_wstrb = data_wstrb;
        mem_wdata = data_wdata;
      end else if (gnt_i) begin
        mem_size = 3'd2;
        mem_addr = inst_addr;
      end
      inst_addr_ok = gnt_i && mem_addr_ok;
      data_addr_ok = gnt_d && mem_addr_ok;
      inst_data_ok = pop && !head_owner;
      data_data_ok = pop && head_owner;
      inst_rdata   = mem_rdata;
      data_rdata   = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q[wr_ptr_q] <= gnt_d;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({accept, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Table-driven bench for mem_req_arbiter; a queue of expected response owners
// is filled on expected accepts and drained on mem_data_ok pulses.
module tb_mem_req_arbiter;

  localparam logic [31:0] IADDR  = 32'hBFC0_0100;
  localparam logic [31:0] DADDR  = 32'h1FC0_0010;
  localparam logic [31:0] DWDATA = 32'hCAFE_F00D;
  localparam logic [1:0]  G0 = 2'd0, GI = 2'd1, GD = 2'd2;
`ifdef ARB_ROUND_ROBIN_EN
  localparam logic [1:0]  TIE_ALT = GI;
`else
  localparam logic [1:0]  TIE_ALT = GD;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        inst_req = 1'b0, data_req = 1'b0, data_wr = 1'b0;
  logic [31:0] inst_addr = IADDR, data_addr = DADDR, data_wdata = DWDATA;
  logic [2:0]  data_size = 3'd2;
  logic [3:0]  data_wstrb = 4'hF;
  logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic        mem_req, mem_wr;
  logic [2:0]  mem_size;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       rst, ir, dr, dwr, aok, dok;
    logic [1:0] eg;
  } vec_t;

  vec_t vecs[$];
  bit   sb[$];

  always #5 clk = ~clk;

  mem_req_arbiter #(.OUTSTANDING_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  function automatic vec_t mk(logic rst, logic ir, logic dr, logic dwr,
                              logic aok, logic dok, logic [1:0] eg);
    vec_t v;
    v.rst = rst; v.ir = ir; v.dr = dr; v.dwr = dwr;
    v.aok = aok; v.dok = dok; v.eg = eg;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic        e_ido, e_ddo;
    logic [31:0] e_rd;
    bit          owner;
    @(negedge clk);
    reset       = v.rst;
    inst_req    = v.ir;
    data_req    = v.dr;
    data_wr     = v.dwr;
    mem_addr_ok = v.aok;
    mem_data_ok = v.dok;
    mem_rdata   = 32'hD000_0000 + 32'(idx);
    #1;
    e_ido = 1'b0;
    e_ddo = 1'b0;
    e_rd  = v.rst ? 32'd0 : 32'hD000_0000 + 32'(idx);
    if (!v.rst && v.dok && sb.size() != 0) begin
      owner = sb.pop_front();
      e_ido = !owner;
      e_ddo = owner;
    end
    chk("mem_req",      idx, 32'(mem_req),      32'(v.eg != G0));
    chk("inst_addr_ok", idx, 32'(inst_addr_ok), 32'(v.eg == GI && v.aok));
    chk("data_addr_ok", idx, 32'(data_addr_ok), 32'(v.eg == GD && v.aok));
    chk("mem_addr",     idx, mem_addr,  (v.eg == GD) ? DADDR : (v.eg == GI) ? IADDR : 32'd0);
    chk("mem_wr",       idx, 32'(mem_wr),       32'(v.eg == GD && v.dwr));
    chk("mem_wdata",    idx, mem_wdata, (v.eg == GD) ? DWDATA : 32'd0);
    chk("mem_size",     idx, 32'(mem_size),     (v.eg != G0) ? 32'd2 : 32'd0);
    chk("mem_wstrb",    idx, 32'(mem_wstrb),    (v.eg == GD) ? 32'hF : 32'd0);
    chk("inst_data_ok", idx, 32'(inst_data_ok), 32'(e_ido));
    chk("data_data_ok", idx, 32'(data_data_ok), 32'(e_ddo));
    chk("inst_rdata",   idx, inst_rdata, e_rd);
    chk("data_rdata",   idx, data_rdata, e_rd);
    if (!v.rst && v.eg != G0 && v.aok)
      sb.push_back(v.eg == GD);
    if (v.rst)
      sb.delete();
  endtask

  initial begin
    int n;
    //                rst ir dr wr aok dok grant
    vecs.push_back(mk(1, 1, 1, 0, 1, 0, G0));      // reset cycle, requests already up
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, GD));      // first tie after reset goes to data
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, TIE_ALT));
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, GD));
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, TIE_ALT));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, G0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, G0));      // stray response on empty FIFO
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, GD));      // store held for 3 cycles
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, GD));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, GD));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, GD));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, G0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, GI));      // held inst request then dropped
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, G0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, G0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, GI));      // fill: I, D, I, D
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, GD));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, GI));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, GD));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, G0));      // full blocks
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, G0));      // full + pop: still blocked
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, GI));      // count 3: accept + pop
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, GD));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, G0));      // full again proves count stayed 3
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, G0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, G0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, G0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, G0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, G0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, GI));      // two outstanding then reset
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, GD));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, G0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, G0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, G0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 0, GI));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, G0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, G0));

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);
    n = vecs.size();

    // Reset while a data grant is held must return the FSM to IDLE.
    apply(mk(0, 0, 1, 0, 0, 0, GD), n);
    apply(mk(1, 0, 1, 0, 0, 0, G0), n + 1);
    apply(mk(0, 1, 0, 0, 1, 0, GI), n + 2);
    apply(mk(0, 0, 0, 0, 0, 1, G0), n + 3);
    apply(mk(0, 0, 0, 0, 0, 0, G0), n + 4);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drained actual=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
